// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing parameters for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RELEASE  = 2'd1,
        ST_RUN      = 2'd2,
        ST_SHUTDOWN = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_STAGES  = 3;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_STAGE_DLY   = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Staged reset release: holds all downstream resets, releases them one by one
// (bit 0 first), and tears them down in reverse order on a software request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_DLY   = DEF_STAGE_DLY
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  sw_rst_req_i,
    output logic [NUM_STAGES-1:0] rstn_o,
    output logic                  sw_rst_ack_o,
    output logic                  all_released_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_DLY) + 1);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
    // Next bit to clear once the top stage has dropped; unused when NUM_STAGES is 1.
    localparam logic [IDX_W-1:0] SD_START  = IDX_W'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);

    if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES must be in 1..16");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_DLY < 1) begin : g_bad_stage_dly
        $error("reset_sequencer: STAGE_DLY must be >= 1");
    end

    seq_state_e            state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [NUM_STAGES-1:0] stage_bit;

    assign stage_bit = NUM_STAGES'(1) << idx;

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= ST_HOLD;
            cnt            <= '0;
            idx            <= '0;
            rstn_o         <= '0;
            sw_rst_ack_o   <= 1'b0;
            all_released_o <= 1'b0;
            busy_o         <= 1'b1;
        end else begin
            sw_rst_ack_o <= 1'b0;
            unique case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt == DLY_LAST) begin
                        cnt    <= '0;
                        rstn_o <= rstn_o | stage_bit;
                        if (idx == LAST_IDX) begin
                            state          <= ST_RUN;
                            idx            <= '0;
                            all_released_o <= 1'b1;
                            busy_o         <= 1'b0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    if (sw_rst_req_i) begin
                        rstn_o[NUM_STAGES-1] <= 1'b0;
                        all_released_o       <= 1'b0;
                        busy_o               <= 1'b1;
                        cnt                  <= '0;
                        if (NUM_STAGES == 1) begin
                            // Single stage: teardown completes on the request edge.
                            state        <= ST_HOLD;
                            idx          <= '0;
                            sw_rst_ack_o <= 1'b1;
                        end else begin
                            state <= ST_SHUTDOWN;
                            idx   <= SD_START;
                        end
                    end
                end

                ST_SHUTDOWN: begin
                    rstn_o <= rstn_o & ~stage_bit;
                    if (idx == '0) begin
                        state        <= ST_HOLD;
                        cnt          <= '0;
                        sw_rst_ack_o <= 1'b1;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end

                default: begin
                    state  <= ST_HOLD;
                    cnt    <= '0;
                    idx    <= '0;
                    rstn_o <= '0;
                    busy_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default build and a 1/1/1 build driven side by side,
// checked against an edge-count timing model plus known-answer points.
module tb_reset_sequencer;

    localparam int NA = 3, HA = 4, SA = 3;
    localparam int NB = 1, HB = 1, SB = 1;
    localparam int PERIOD_A = NA + HA + NA * SA;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    logic req_a  = 1'b0;
    logic req_b  = 1'b0;

    logic [NA-1:0] rstn_a;
    logic          ack_a, rel_a, busy_a;
    logic [NB-1:0] rstn_b;
    logic          ack_b, rel_b, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    reset_sequencer #(.NUM_STAGES(NA), .HOLD_CYCLES(HA), .STAGE_DLY(SA)) dut_a (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .sw_rst_req_i   (req_a),
        .rstn_o         (rstn_a),
        .sw_rst_ack_o   (ack_a),
        .all_released_o (rel_a),
        .busy_o         (busy_a)
    );

    reset_sequencer #(.NUM_STAGES(NB), .HOLD_CYCLES(HB), .STAGE_DLY(SB)) dut_b (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .sw_rst_req_i   (req_b),
        .rstn_o         (rstn_b),
        .sw_rst_ack_o   (ack_b),
        .all_released_o (rel_b),
        .busy_o         (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Timing model: t0 is the edge before "edge 1" of the current hold/release run;
    // n_sd is the edge on which a shutdown request was taken.
    typedef struct {
        int          t0;
        int          n_sd;
        bit          shutting;
        bit          ack;
        logic [15:0] exp;
    } model_t;

    function automatic model_t model_reset(input int t);
        model_t r;
        r.t0 = t; r.n_sd = 0; r.shutting = 1'b0; r.ack = 1'b0; r.exp = '0;
        return r;
    endfunction

    function automatic model_t step(input model_t m, input int n, input int h,
                                    input int s, input int t, input bit req);
        model_t r = m;
        r.ack = 1'b0;
        if (r.shutting) begin
            int j = t - r.n_sd;
            r.exp = '0;
            for (int k = 0; k < n; k++) r.exp[k] = (k < n - 1 - j);
            if (j >= n - 1) begin
                r.ack = 1'b1; r.shutting = 1'b0; r.t0 = t;
            end
        end else if ((t - 1 - r.t0 >= h + n * s) && req) begin
            r.n_sd = t;
            r.exp  = '0;
            for (int k = 0; k < n - 1; k++) r.exp[k] = 1'b1;
            if (n == 1) begin
                r.ack = 1'b1; r.t0 = t;
            end else begin
                r.shutting = 1'b1;
            end
        end else begin
            int e = t - r.t0;
            r.exp = '0;
            for (int k = 0; k < n; k++) r.exp[k] = (e >= h + (k + 1) * s);
        end
        return r;
    endfunction

    int     t   = 0;
    model_t m_a = '{0, 0, 1'b0, 1'b0, 16'h0};
    model_t m_b = '{0, 0, 1'b0, 1'b0, 16'h0};

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_a = model_reset(t);
            m_b = model_reset(t);
        end else begin
            t++;
            m_a = step(m_a, NA, HA, SA, t, req_a);
            m_b = step(m_b, NB, HB, SB, t, req_b);
        end
    end

    always @(posedge clk_i) begin
        #3;
        check("mdl_a_rstn", 32'(rstn_a), 32'(m_a.exp[NA-1:0]));
        check("mdl_a_ack",  32'(ack_a),  32'(m_a.ack));
        check("mdl_a_rel",  32'(rel_a),  32'(m_a.exp[NA-1:0] == '1));
        check("mdl_a_busy", 32'(busy_a), 32'(m_a.exp[NA-1:0] != '1));
        check("mdl_b_rstn", 32'(rstn_b), 32'(m_b.exp[NB-1:0]));
        check("mdl_b_ack",  32'(ack_b),  32'(m_b.ack));
        check("mdl_b_rel",  32'(rel_b),  32'(m_b.exp[NB-1:0] == '1));
        check("mdl_b_busy", 32'(busy_b), 32'(m_b.exp[NB-1:0] != '1));
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_a_rstn"}, 32'(rstn_a), 32'h0);
        check({tag, "_a_ack"},  32'(ack_a),  32'h0);
        check({tag, "_a_rel"},  32'(rel_a),  32'h0);
        check({tag, "_a_busy"}, 32'(busy_a), 32'h1);
        check({tag, "_b_rstn"}, 32'(rstn_b), 32'h0);
        check({tag, "_b_ack"},  32'(ack_b),  32'h0);
        check({tag, "_b_rel"},  32'(rel_b),  32'h0);
        check({tag, "_b_busy"}, 32'(busy_b), 32'h1);
    endtask

    initial begin
        int acks, rels, pairs;
        bit prev_rel;

        repeat (3) @(negedge clk_i);
        check_reset_state("por");

        // NOTE: stimulus uses blocking = from the bench process, changed on the
        // falling edge so the DUT and the model both sample a settled value.
        rstn_i = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            req_a = (e == 9 || e == 20);
            req_b = (e == 5);
            @(negedge clk_i);
            if (e == 6)  check("pwr_a_6",  32'(rstn_a), 32'b000);
            if (e == 7)  check("pwr_a_7",  32'(rstn_a), 32'b001);
            if (e == 9)  check("ign_a_9",  32'(rstn_a), 32'b001);
            if (e == 10) check("pwr_a_10", 32'(rstn_a), 32'b011);
            if (e == 13) begin
                check("pwr_a_13",     32'(rstn_a), 32'b111);
                check("pwr_a_rel_13", 32'(rel_a),  32'h1);
                check("pwr_a_busy13", 32'(busy_a), 32'h0);
            end
            if (e == 20) begin
                check("sw_a_20",     32'(rstn_a), 32'b011);
                check("sw_a_rel_20", 32'(rel_a),  32'h0);
            end
            if (e == 21) check("sw_a_21",     32'(rstn_a), 32'b001);
            if (e == 22) begin
                check("sw_a_22",     32'(rstn_a), 32'b000);
                check("sw_a_ack_22", 32'(ack_a),  32'h1);
            end
            if (e == 23) check("sw_a_ack_23", 32'(ack_a), 32'h0);
            if (e == 29) check("sw_a_29", 32'(rstn_a), 32'b001);
            if (e == 35) check("sw_a_35", 32'(rstn_a), 32'b111);
            if (e == 1)  check("b_1",      32'(rstn_b), 32'h0);
            if (e == 2)  check("b_2",      32'(rstn_b), 32'h1);
            if (e == 2)  check("b_rel_2",  32'(rel_b),  32'h1);
            if (e == 5)  check("b_5",      32'(rstn_b), 32'h0);
            if (e == 5)  check("b_ack_5",  32'(ack_b),  32'h1);
            if (e == 6)  check("b_ack_6",  32'(ack_b),  32'h0);
            if (e == 7)  check("b_7",      32'(rstn_b), 32'h1);
        end
        req_a = 1'b0;
        req_b = 1'b0;

        // Reset while running, then again in the middle of a release.
        rstn_i = 1'b0;
        #1 check_reset_state("rst_run");
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check("mid_pre_10", 32'(rstn_a), 32'b011);
        rstn_i = 1'b0;
        #1 check_reset_state("rst_mid");
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk_i);
            if (e == 7)  check("restart_a_7",  32'(rstn_a), 32'b001);
            if (e == 13) check("restart_a_13", 32'(rstn_a), 32'b111);
        end

        // Request held high across several full teardown/release cycles.
        acks = 0; rels = 0; pairs = 0; prev_rel = 1'b0;
        req_a = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk_i);
            if (ack_a) acks++;
            if (rel_a) rels++;
            if (rel_a && prev_rel) pairs++;
            prev_rel = rel_a;
        end
        req_a = 1'b0;
        check("held_acks",  32'(acks),  32'((80 - NA) / PERIOD_A + 1));
        check("held_rels",  32'(rels),  32'(80 / PERIOD_A));
        check("held_pairs", 32'(pairs), 32'h0);

        // Random requests with occasional asynchronous resets at any point.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rstn_i = 1'b0;
                #1 check_reset_state("rnd_rst");
                @(negedge clk_i);
                rstn_i = 1'b1;
            end
            req_a = ($urandom_range(0, 5) == 0);
            req_b = ($urandom_range(0, 3) == 0);
            @(negedge clk_i);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of downstream reset outputs, legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 4: minimum cycles all outputs stay asserted after reset or shutdown, legal range >=1.
REQ-003 Parameter STAGE_DLY, default 3: cycles between successive stage releases, legal range >=1.
REQ-004 Port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rstn_i, input, 1: reset, asynchronous assert, active-low; driven from the reset_synchronizer output, so deassertion is already clock-aligned.
REQ-006 Port sw_rst_req_i, input, 1: software reset request, level-sampled each cycle.
REQ-007 Port rstn_o, output, NUM_STAGES: per-stage active-low resets; bit 0 is released first.
REQ-008 Port sw_rst_ack_o, output, 1: one-cycle pulse when a software shutdown completes.
REQ-009 Port all_released_o, output, 1: high exactly while every rstn_o bit is 1.
REQ-010 Port busy_o, output, 1: high whenever state is not RUN.

Function
REQ-011 The FSM SHALL have exactly four states: HOLD, RELEASE, RUN and SHUTDOWN.
REQ-012 HOLD SHALL keep all rstn_o at 0, count HOLD_CYCLES cycles, then go to RELEASE with the counter cleared and stage index 0.
REQ-013 RELEASE SHALL count STAGE_DLY cycles, then on that edge set rstn_o[idx]=1 and increment idx; after releasing bit NUM_STAGES-1, go to RUN.
REQ-014 Timing SHALL be counted from edge 1, the first rising edge sampling rstn_i=1; rstn_o[k] rises at edge HOLD_CYCLES+(k+1)*STAGE_DLY. Defaults: edges 7, 10, 13.
REQ-015 all_released_o SHALL rise on the same edge as the last stage release, and busy_o SHALL fall on that edge.
REQ-016 In RUN, sw_rst_req_i=1 sampled at edge n SHALL clear rstn_o[NUM_STAGES-1] and all_released_o at edge n and enter SHUTDOWN.
REQ-017 SHUTDOWN SHALL clear one further bit per edge in descending order, so rstn_o[0] clears at edge n+NUM_STAGES-1.
REQ-018 The edge that clears rstn_o[0] SHALL also set sw_rst_ack_o=1 for exactly one cycle and enter HOLD.
REQ-019 sw_rst_req_i SHALL be ignored in HOLD, RELEASE and SHUTDOWN; requests are not queued.
REQ-020 A request still held high when RUN is re-entered SHALL start a new shutdown at the next edge.
REQ-021 With NUM_STAGES=1, shutdown SHALL clear rstn_o[0], pulse sw_rst_ack_o and enter HOLD all on edge n.
REQ-022 Released bits SHALL never reassert in RELEASE or RUN, and unreleased bits SHALL never deassert in HOLD or SHUTDOWN.
REQ-023 All outputs SHALL be registered, with no combinational path from sw_rst_req_i to any output.
REQ-024 The counter width SHALL be clog2(max(HOLD_CYCLES,STAGE_DLY)+1); the stage index width SHALL be clog2(NUM_STAGES+1).

Reset
REQ-025 rstn_i=0 SHALL asynchronously force: state HOLD, counter 0, idx 0, rstn_o all 0, sw_rst_ack_o 0, all_released_o 0, busy_o 1.
REQ-026 rstn_i falling in any state, including mid-RELEASE or mid-SHUTDOWN, SHALL abort the sequence immediately with no ack pulse.
REQ-027 Reset assertion SHALL not depend on clk_i running.

Structure
REQ-028 Package reset_seq_pkg SHALL hold the state enum and the default values of NUM_STAGES, HOLD_CYCLES and STAGE_DLY.
REQ-029 The block SHALL be a single flat module (one FSM, one counter, one index register) with no sub-module; rstn_i conditioning stays in the upstream reset_synchronizer.
REQ-030 Illegal parameter values SHALL be rejected at elaboration by an assertion.

Verification
REQ-031 Power-up, defaults: rstn_i 0 to 1 before edge 1 -> rstn_o 000, then 001@7, 011@10, 111@13; all_released_o=1@13.
REQ-032 Software reset: 1-cycle sw_rst_req_i sampled @20 -> rstn_o 011@20, 001@21, 000@22; sw_rst_ack_o high 22..23; 001@29, 111@35.
REQ-033 Ignored request: pulse sw_rst_req_i @9 during RELEASE -> sequence unchanged, no ack.
REQ-034 Reset mid-release: rstn_i low between edges 10 and 11 -> rstn_o=000 immediately, no ack; restart timing per REQ-014 from the new edge 1.
REQ-035 Held request: sw_rst_req_i held high from edge 20 -> repeated shutdown/release cycles, one ack per cycle, and all_released_o high for only one cycle each time.
REQ-036 NUM_STAGES=1, HOLD_CYCLES=1, STAGE_DLY=1 -> release @2; request @5 -> rstn_o=0 and ack @5, release again @7.
